rx_8b9b_link: RTL

- Single-clock receiver for the 8b9b framed serial stream generated by tx_8b9b; the far-end counterpart of the transmitter on the K7–S6 inter-chip link.
- Samples an asynchronous single-bit line OVERSAMPLE clocks per bit, with no 4x SERDES clock and no PLL dependence.
- Recovers 8-bit words and frame boundaries and presents them with the same word_write / frame_complete semantics as the oversampling receiver, so it is a drop-in where a 4x clock is unavailable.

---
 rtl/rx_8b9b_pkg.sv | 21 ++
 rtl/rx_8b9b_link_if.sv | 33 +++
 rtl/bit_sync_2ff.sv | 26 ++
 rtl/rx_8b9b_link.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rx_8b9b_pkg.sv
// rtl/rx_8b9b_pkg.sv - receiver state encoding and width helper for the 8b9b link
package rx_8b9b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_GAP   = 2'd3
  } rx_state_e;

  // Minimum of 1 bit so a degenerate width never produces a zero-width vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rx_8b9b_link_if.sv
// rtl/rx_8b9b_link_if.sv - line input and word/frame strobes of the 8b9b receiver
interface rx_8b9b_link_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   data_in;
  logic [WORD_WIDTH-1:0]  word_out;
  logic                   word_write;
  logic                   frame_complete;
  logic [COUNT_WIDTH-1:0] frame_words;
  logic                   start_error;

  modport master (
    input  enable,
    input  data_in,
    output word_out,
    output word_write,
    output frame_complete,
    output frame_words,
    output start_error
  );

  modport slave (
    output enable,
    output data_in,
    input  word_out,
    input  word_write,
    input  frame_complete,
    input  frame_words,
    input  start_error
  );
endinterface

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module bit_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rx_8b9b_link.sv
// rtl/rx_8b9b_link.sv - oversampling 8b9b frame receiver; phase locked once per frame at the idle falling edge
module rx_8b9b_link
  import rx_8b9b_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int OVERSAMPLE  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           async_reset_n,
  rx_8b9b_link_if.master bus
);

  localparam int PH_W  = clog2(OVERSAMPLE);
  localparam int BIT_W = clog2(WORD_WIDTH);
  localparam logic [PH_W-1:0]  PH_FULL  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  logic                   w_s;
  logic                   w_ph_zero;
  logic                   r_s_prev;
  rx_state_e              r_state,          w_state_nxt;
  logic [PH_W-1:0]        r_ph,             w_ph_nxt;
  logic [BIT_W-1:0]       r_bit_idx,        w_bit_nxt;
  logic [WORD_WIDTH-1:0]  r_shift,          w_shift_nxt;
  logic [COUNT_WIDTH-1:0] r_count,          w_count_nxt;
  logic                   r_word_pend,      w_word_pend_nxt;
  logic                   r_frame_pend,     w_frame_pend_nxt;
  logic [WORD_WIDTH-1:0]  r_word_out,       w_word_out_nxt;
  logic                   r_word_write,     w_word_write_nxt;
  logic                   r_frame_complete, w_frame_complete_nxt;
  logic [COUNT_WIDTH-1:0] r_frame_words,    w_frame_words_nxt;
  logic                   r_start_error,    w_start_error_nxt;

  bit_sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (async_reset_n),
    .i_d     (bus.data_in),
    .o_q     (w_s)
  );

  assign w_ph_zero = (r_ph == '0);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_s_prev         <= 1'b1;
      r_state          <= ST_IDLE;
      r_ph             <= '0;
      r_bit_idx        <= '0;
      r_shift          <= '0;
      r_count          <= '0;
      r_word_pend      <= 1'b0;
      r_frame_pend     <= 1'b0;
      r_word_out       <= '0;
      r_word_write     <= 1'b0;
      r_frame_complete <= 1'b0;
      r_frame_words    <= '0;
      r_start_error    <= 1'b0;
    end else begin
      r_s_prev         <= w_s;
      r_state          <= w_state_nxt;
      r_ph             <= w_ph_nxt;
      r_bit_idx        <= w_bit_nxt;
      r_shift          <= w_shift_nxt;
      r_count          <= w_count_nxt;
      r_word_pend      <= w_word_pend_nxt;
      r_frame_pend     <= w_frame_pend_nxt;
      r_word_out       <= w_word_out_nxt;
      r_word_write     <= w_word_write_nxt;
      r_frame_complete <= w_frame_complete_nxt;
      r_frame_words    <= w_frame_words_nxt;
      r_start_error    <= w_start_error_nxt;
    end
  end

  // Word and frame-end events are detected at the mid-slot sample and published one
  // cycle later, which keeps frame_complete exactly one bit time behind word_write.
  always_comb begin
    w_state_nxt          = r_state;
    w_ph_nxt             = r_ph;
    w_bit_nxt            = r_bit_idx;
    w_shift_nxt          = r_shift;
    w_count_nxt          = r_count;
    w_word_pend_nxt      = 1'b0;
    w_frame_pend_nxt     = 1'b0;
    w_word_out_nxt       = r_word_out;
    w_word_write_nxt     = 1'b0;
    w_frame_complete_nxt = 1'b0;
    w_frame_words_nxt    = r_frame_words;
    w_start_error_nxt    = 1'b0;

    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      if (r_word_pend) begin
        w_word_out_nxt   = r_shift;
        w_word_write_nxt = 1'b1;
      end
      if (r_frame_pend) begin
        w_frame_complete_nxt = 1'b1;
        w_frame_words_nxt    = r_count;
        w_count_nxt          = '0;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (r_s_prev && !w_s) begin
            w_ph_nxt    = PH_HALF;
            w_state_nxt = ST_START;
          end
        end

        ST_START: begin
          if (!w_ph_zero) begin
            w_ph_nxt = r_ph - PH_W'(1);
          end else if (!w_s) begin
            w_shift_nxt = '0;
            w_bit_nxt   = '0;
            w_ph_nxt    = PH_FULL;
            w_state_nxt = ST_DATA;
          end else begin
            w_start_error_nxt = 1'b1;
            w_frame_pend_nxt  = (r_count != '0);
            w_state_nxt       = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (!w_ph_zero) begin
            w_ph_nxt = r_ph - PH_W'(1);
          end else begin
            w_shift_nxt = {w_s, r_shift[WORD_WIDTH-1:1]};
            w_ph_nxt    = PH_FULL;
            if (r_bit_idx == BIT_LAST) begin
              w_word_pend_nxt = 1'b1;
              w_count_nxt     = (r_count == '1) ? r_count : r_count + COUNT_WIDTH'(1);
              w_state_nxt     = ST_GAP;
            end else begin
              w_bit_nxt = r_bit_idx + BIT_W'(1);
            end
          end
        end

        ST_GAP: begin
          if (!w_ph_zero) begin
            w_ph_nxt = r_ph - PH_W'(1);
          end else if (!w_s) begin
            w_bit_nxt   = '0;
            w_ph_nxt    = PH_FULL;
            w_state_nxt = ST_DATA;
          end else begin
            w_frame_pend_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.word_out       = r_word_out;
  assign bus.word_write     = r_word_write;
  assign bus.frame_complete = r_frame_complete;
  assign bus.frame_words    = r_frame_words;
  assign bus.start_error    = r_start_error;

endmodule
